// File: rtl/dmem_port_b_host.sv
// Host-side sequencer for port B of the dual-port data memory: streams bytes in
// (one per word, then a length word) and streams a result string back out.
module dmem_port_b_host #(
  parameter logic [31:0] IN_BASE  = 32'h0000_0040,
  parameter logic [31:0] LEN_ADDR = 32'h0000_003F,
  parameter logic [31:0] OUT_BASE = 32'h0000_0080,
  parameter int unsigned MAX_LEN  = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        dump_start,
  input  logic [7:0]  dump_len,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [31:0] dataadr_b,
  output logic [31:0] writedata_b,
  output logic        memwrite_b,
  input  logic [7:0]  ascii,
  output logic        busy,
  output logic        done,
  output logic        overflow
);

  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  typedef enum logic [2:0] {IDLE, LOAD, LEN, D_ISSUE, D_WAIT, D_PRESENT} state_t;

  state_t      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  i_q, i_d;
  logic [7:0]  n_q, n_d;
  logic        len_ph_q, len_ph_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        mwe_q, mwe_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        done_q, done_d;
  logic        ovf_q, ovf_d;
  logic        is_last;

  assign is_last     = (i_q == n_q - 8'd1);
  assign in_ready    = (state_q == LOAD);
  assign out_valid   = (state_q == D_PRESENT);
  assign out_last    = out_valid && is_last;
  assign busy        = (state_q != IDLE);
  assign dataadr_b   = adr_q;
  assign writedata_b = wdata_q;
  assign memwrite_b  = mwe_q;
  assign out_data    = out_data_q;
  assign done        = done_q;
  assign overflow    = ovf_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      i_q        <= '0;
      n_q        <= '0;
      len_ph_q   <= 1'b0;
      adr_q      <= '0;
      wdata_q    <= '0;
      mwe_q      <= 1'b0;
      out_data_q <= '0;
      done_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      i_q        <= i_d;
      n_q        <= n_d;
      len_ph_q   <= len_ph_d;
      adr_q      <= adr_d;
      wdata_q    <= wdata_d;
      mwe_q      <= mwe_d;
      out_data_q <= out_data_d;
      done_q     <= done_d;
      ovf_q      <= ovf_d;
    end
  end

  // The read address is registered on the edge into D_ISSUE so that ascii
  // is already valid in D_WAIT, giving the 3-cycle-per-byte dump loop.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    i_d        = i_q;
    n_d        = n_q;
    len_ph_d   = len_ph_q;
    adr_d      = adr_q;
    wdata_d    = wdata_q;
    mwe_d      = 1'b0;
    out_data_d = out_data_q;
    done_d     = 1'b0;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE: begin
        if (load_start) begin
          state_d = LOAD;
          idx_d   = '0;
          ovf_d   = 1'b0;
        end else if (dump_start) begin
          if (dump_len == 8'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = D_ISSUE;
            i_d     = '0;
            n_d     = dump_len;
            adr_d   = OUT_BASE;
          end
        end
      end
      LOAD: begin
        if (in_valid) begin
          if (idx_q < MAX_LEN_B) begin
            adr_d   = IN_BASE + 32'(idx_q);
            wdata_d = {24'b0, in_data};
            mwe_d   = 1'b1;
            idx_d   = idx_q + 8'd1;
          end else begin
            ovf_d = 1'b1;
          end
          if (in_last) begin
            state_d  = LEN;
            len_ph_d = 1'b0;
          end
        end
      end
      // First LEN cycle issues the length write; second finishes the load.
      LEN: begin
        if (!len_ph_q) begin
          adr_d    = LEN_ADDR;
          wdata_d  = {24'b0, idx_q};
          mwe_d    = 1'b1;
          len_ph_d = 1'b1;
        end else begin
          state_d  = IDLE;
          len_ph_d = 1'b0;
          done_d   = 1'b1;
        end
      end
      D_ISSUE: begin
        state_d = D_WAIT;
      end
      D_WAIT: begin
        out_data_d = ascii;
        state_d    = D_PRESENT;
      end
      D_PRESENT: begin
        if (out_ready) begin
          i_d = i_q + 8'd1;
          if (is_last) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = D_ISSUE;
            adr_d   = OUT_BASE + 32'(i_q) + 32'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_dmem_port_b_host.sv
// Self-checking bench for dmem_port_b_host: port-B writes and output bytes are
// checked against scoreboard queues; timing and flags are checked per scenario.
module tb_dmem_port_b_host;

  localparam logic [31:0] IN_BASE  = 32'h0000_0040;
  localparam logic [31:0] LEN_ADDR = 32'h0000_003F;
  localparam int          MAX_LEN  = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        load_start = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = 8'h00;
  logic        in_last = 1'b0;
  logic        dump_start = 1'b0;
  logic [7:0]  dump_len = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [31:0] dataadr_b;
  logic [31:0] writedata_b;
  logic        memwrite_b;
  logic [7:0]  ascii = 8'h00;
  logic        busy;
  logic        done;
  logic        overflow;

  int vectors = 0;
  int miscompares = 0;
  int m_idx = 0;

  logic [63:0] exp_wr[$];
  logic [8:0]  exp_out[$];
  logic [63:0] mon_wr;
  logic [8:0]  mon_out;
  logic [7:0]  rom [0:255];

  always #5 clk = ~clk;

  dmem_port_b_host dut (
    .clk(clk), .rst(rst),
    .load_start(load_start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last),
    .dump_start(dump_start), .dump_len(dump_len),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .dataadr_b(dataadr_b), .writedata_b(writedata_b), .memwrite_b(memwrite_b),
    .ascii(ascii), .busy(busy), .done(done), .overflow(overflow)
  );

  // Synchronous-read memory model for the dump region.
  always @(posedge clk) ascii <= rom[dataadr_b[7:0]];

  // Scoreboard: every port-B write and every output handshake is popped and compared.
  always @(negedge clk) begin
    if (memwrite_b) begin
      vectors++;
      if (exp_wr.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_write: got adr=%h data=%h, required no write", dataadr_b, writedata_b);
      end else begin
        mon_wr = exp_wr.pop_front();
        if ({dataadr_b, writedata_b} !== mon_wr) begin
          miscompares++;
          $display("[TB] FAIL port_b_write: got adr=%h data=%h, required adr=%h data=%h",
                   dataadr_b, writedata_b, mon_wr[63:32], mon_wr[31:0]);
        end
      end
    end
    if (out_valid && out_ready) begin
      vectors++;
      if (exp_out.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL unexpected_output: got data=%h last=%b, required no output", out_data, out_last);
      end else begin
        mon_out = exp_out.pop_front();
        if ({out_last, out_data} !== mon_out) begin
          miscompares++;
          $display("[TB] FAIL out_byte: got data=%h last=%b, required data=%h last=%b",
                   out_data, out_last, mon_out[7:0], mon_out[8]);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    m_idx = 0;
  endtask

  // Drives n consecutive bytes starting at 'first' and records the writes they should cause.
  task automatic send_bytes(input int n, input logic [7:0] first, input logic with_last);
    for (int j = 0; j < n; j++) begin
      in_valid = 1'b1;
      in_data  = first + 8'(j);
      in_last  = with_last && (j == n - 1);
      if (m_idx < MAX_LEN) begin
        exp_wr.push_back({IN_BASE + 32'(m_idx), 24'b0, in_data});
        m_idx++;
      end
      step();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    vectors++;
    if ({in_ready, out_valid, out_data, out_last, dataadr_b, writedata_b, memwrite_b, busy, done, overflow} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got rdy=%b ov=%b od=%h ol=%b adr=%h wd=%h we=%b busy=%b done=%b ovf=%b, required all 0",
               in_ready, out_valid, out_data, out_last, dataadr_b, writedata_b, memwrite_b, busy, done, overflow);
    end
    rst = 1'b1;
    step();
  endtask

  task automatic test_load_hi();
    start_load();
    vectors++;
    if ({in_ready, busy} !== 2'b11) begin
      miscompares++;
      $display("[TB] FAIL load_entry: got in_ready=%b busy=%b, required 1 1", in_ready, busy);
    end
    send_bytes(2, 8'h48, 1'b1);
    exp_wr.push_back({LEN_ADDR, 24'b0, 8'(m_idx)});
    vectors++;
    if ({in_ready, busy} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL load_last_ready: got in_ready=%b busy=%b, required 0 1", in_ready, busy);
    end
    step();
    vectors++;
    if ({memwrite_b, dataadr_b, writedata_b} !== {1'b1, LEN_ADDR, 32'd2}) begin
      miscompares++;
      $display("[TB] FAIL len_write_timing: got we=%b adr=%h data=%h, required 1 %h 2", memwrite_b, dataadr_b, writedata_b, LEN_ADDR);
    end
    step();
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL load_done: got done=%b busy=%b, required 1 0", done, busy);
    end
    step();
    vectors++;
    if ({done, overflow} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL load_done_pulse: got done=%b overflow=%b, required 0 0", done, overflow);
    end
    vectors++;
    if (exp_wr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL load_hi_writes: got %0d writes missing, required 0", exp_wr.size());
    end
  endtask

  task automatic test_overflow();
    start_load();
    send_bytes(66, 8'h10, 1'b1);
    exp_wr.push_back({LEN_ADDR, 24'b0, 8'(m_idx)});
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_set: got %b, required 1", overflow);
    end
    step();
    step();
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL overflow_done: got done=%b busy=%b, required 1 0", done, busy);
    end
    for (int c = 0; c < 4; c++) step();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_sticky: got %b, required 1", overflow);
    end
    vectors++;
    if (exp_wr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL overflow_writes: got %0d writes missing, required 0", exp_wr.size());
    end
  endtask

  task automatic test_start_priority();
    load_start = 1'b1;
    dump_start = 1'b1;
    dump_len   = 8'd2;
    step();
    load_start = 1'b0;
    dump_start = 1'b0;
    m_idx = 0;
    vectors++;
    if ({in_ready, out_valid, overflow} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL start_priority: got in_ready=%b out_valid=%b overflow=%b, required 1 0 0", in_ready, out_valid, overflow);
    end
    dump_start = 1'b1;
    dump_len   = 8'd1;
    send_bytes(2, 8'h61, 1'b1);
    dump_start = 1'b0;
    exp_wr.push_back({LEN_ADDR, 24'b0, 8'(m_idx)});
    step();
    step();
    vectors++;
    if (done !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL priority_load_done: got done=%b, required 1", done);
    end
    step();
    step();
    vectors++;
    if ({busy, out_valid} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL dump_dropped: got busy=%b out_valid=%b, required 0 0", busy, out_valid);
    end
    vectors++;
    if (exp_wr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL priority_writes: got %0d writes missing, required 0", exp_wr.size());
    end
  endtask

  task automatic test_dump();
    int first_valid;
    int hs;
    int stall;
    logic [7:0] held;
    logic fired;
    logic lastfire;
    logic finished;
    rom[8'h80] = "A";
    rom[8'h81] = "B";
    rom[8'h82] = "C";
    exp_out.push_back({1'b0, 8'h41});
    exp_out.push_back({1'b0, 8'h42});
    exp_out.push_back({1'b1, 8'h43});
    first_valid = -1;
    hs = 0;
    stall = 0;
    held = 8'h00;
    finished = 1'b0;
    dump_len   = 8'd3;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    out_ready  = 1'b1;
    for (int cyc = 0; cyc < 60; cyc++) begin
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && hs == 1 && stall < 4) begin
        out_ready = 1'b0;
        if (stall > 0) begin
          vectors++;
          if (out_data !== held) begin
            miscompares++;
            $display("[TB] FAIL stall_stable: got %h, required %h", out_data, held);
          end
        end
        held = out_data;
        stall++;
      end else begin
        out_ready = 1'b1;
      end
      fired    = out_valid && out_ready;
      lastfire = fired && out_last;
      if (fired) hs++;
      step();
      if (lastfire) begin
        finished = 1'b1;
        break;
      end
    end
    vectors++;
    if (!finished) begin
      miscompares++;
      $display("[TB] FAIL dump_timeout: got %0d handshakes, required last byte within 60 cycles", hs);
    end
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL dump_done: got done=%b busy=%b, required 1 0", done, busy);
    end
    vectors++;
    if (first_valid !== 2) begin
      miscompares++;
      $display("[TB] FAIL dump_latency: got out_valid after %0d cycles, required 2", first_valid);
    end
    out_ready = 1'b0;
    step();
    vectors++;
    if ({done, exp_out.size() == 0} !== 2'b01) begin
      miscompares++;
      $display("[TB] FAIL dump_complete: got done=%b pending=%0d, required done=0 pending=0", done, exp_out.size());
    end
  endtask

  task automatic test_dump_zero();
    dump_len   = 8'd0;
    dump_start = 1'b1;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL zero_busy_before: got %b, required 0", busy);
    end
    step();
    dump_start = 1'b0;
    vectors++;
    if ({done, busy} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL zero_done: got done=%b busy=%b, required 1 0", done, busy);
    end
    step();
    vectors++;
    if ({done, busy, memwrite_b, out_valid} !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL zero_after: got done=%b busy=%b we=%b ov=%b, required 0 0 0 0", done, busy, memwrite_b, out_valid);
    end
  endtask

  task automatic test_reset_mid_load();
    start_load();
    send_bytes(3, 8'h30, 1'b0);
    rst = 1'b0;
    step();
    vectors++;
    if ({in_ready, out_valid, out_data, out_last, dataadr_b, writedata_b, memwrite_b, busy, done, overflow} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midload_reset: got rdy=%b ov=%b od=%h ol=%b adr=%h wd=%h we=%b busy=%b done=%b ovf=%b, required all 0",
               in_ready, out_valid, out_data, out_last, dataadr_b, writedata_b, memwrite_b, busy, done, overflow);
    end
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      vectors++;
      if ({busy, done, memwrite_b} !== 3'b000) begin
        miscompares++;
        $display("[TB] FAIL midload_after: got busy=%b done=%b we=%b, required 0 0 0", busy, done, memwrite_b);
      end
    end
    vectors++;
    if (exp_wr.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL midload_writes: got %0d writes missing, required 0", exp_wr.size());
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish by 100000ns, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_load_hi();
    test_overflow();
    test_start_priority();
    test_dump();
    test_dump_zero();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
